// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the MDU sequencer: operation codes, FSM states and
// the multi-cycle op-class helper.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MTHI     = 4'd5,
    MTLO     = 4'd6,
    MFHI     = 4'd7,
    MFLO     = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; res_hi/res_lo follow HI/LO layout
// (product upper/lower, or remainder/quotient).
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    prod   = '0;
    case (op)
      MULT: begin
        prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MULTU: begin
        prod   = {32'b0, a} * {32'b0, b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      DIV: begin
        // The only signed overflow case is pinned so it never depends on the
        // simulator/synthesis handling of -2^31 / -1.
        if (a == 32'h8000_0000 && b == '1) begin
          res_lo = 32'h8000_0000;
          res_hi = '0;
        end else if (b != '0) begin
          res_lo = $signed(a) / $signed(b);
          res_hi = $signed(a) % $signed(b);
        end
      end
      DIVU: begin
        if (b != '0) begin
          res_lo = a / b;
          res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: HI/LO registers, multi-cycle FSM and D-stage stall request.
// Optional MDU_FLUSH_EN adds a flush port that aborts a pending operation.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_mlu_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  mdu_state_e  state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] stg_hi, stg_hi_n, stg_lo, stg_lo_n;
  logic [31:0] hi_n, lo_n;
  logic [31:0] ar_hi, ar_lo;

  mdu_arith u_arith (
    .op     (op),
    .a      (rs_val),
    .b      (rt_val),
    .res_hi (ar_hi),
    .res_lo (ar_lo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      stg_hi <= '0;
      stg_lo <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      stg_hi <= stg_hi_n;
      stg_lo <= stg_lo_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stg_hi_n = stg_hi;
    stg_lo_n = stg_lo;
    hi_n     = hi;
    lo_n     = lo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MULT, MULTU: begin
              stg_hi_n = ar_hi;
              stg_lo_n = ar_lo;
              cnt_n    = 4'(MULT_CYCLES);
              state_n  = ST_MUL;
            end
            DIV, DIVU: begin
              // Divide by zero stages the current HI/LO so the commit is a no-op.
              stg_hi_n = (rt_val == '0) ? hi : ar_hi;
              stg_lo_n = (rt_val == '0) ? lo : ar_lo;
              cnt_n    = 4'(DIV_CYCLES);
              state_n  = ST_DIV;
            end
            MTHI:    hi_n = rs_val;
            MTLO:    lo_n = rs_val;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi_n    = stg_hi;
          lo_n    = stg_lo;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
`ifdef MDU_FLUSH_EN
    if (flush) begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      stg_hi_n = '0;
      stg_lo_n = '0;
      hi_n     = hi;
      lo_n     = lo;
    end
`endif
  end

  assign busy  = (state != ST_IDLE);
  assign stall = d_mlu_use & (busy | (start & is_multi(op)));
  assign rdata = (op == MFHI) ? hi : (op == MFLO) ? lo : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO pushed at start, popped at
// commit. Build with +define+MDU_FLUSH_EN to also cover flush.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        d_mlu_use = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo, rdata;
`ifdef MDU_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MDU_FLUSH_EN
    .flush     (flush),
`endif
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_mlu_use (d_mlu_use),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: division via magnitudes, then sign fix-up.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] ua, ub, q, r;
    p = {m_hi, m_lo};
    case (o)
      MULT:  p = 64'(longint'(signed'(a)) * longint'(signed'(b)));
      MULTU: p = 64'({32'b0, a}) * 64'({32'b0, b});
      DIV: if (b != 0) begin
        ua = a[31] ? -a : a;
        ub = b[31] ? -b : b;
        q = ua / ub;
        r = ua % ub;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        p = {r, q};
      end
      DIVU: if (b != 0) p = {a % b, a / b};
      default: ;
    endcase
    return p;
  endfunction

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input int unsigned ncyc);
    logic [63:0] e;
    int unsigned n;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = a; rt_val = b; d_mlu_use = use_d;
    #1 chk("stall_t0", 32'(stall), 32'(use_d));
    sb_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      chk("stall_busy", 32'(stall), 32'(use_d));
      chk("hi_hold", hi, m_hi);
      chk("lo_hold", lo, m_lo);
    end
    chk("busy_cycles", n, ncyc);
    chk("stall_after", 32'(stall), 32'd0);
    e = sb_q.pop_front();
    chk("hi_commit", hi, e[63:32]);
    chk("lo_commit", lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
    d_mlu_use = 1'b0;
  endtask

  task automatic move_to(input logic [3:0] o, input logic [31:0] v);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_val = v;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NONE;
    if (o == MTHI) m_hi = v; else m_lo = v;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  initial begin
    d_mlu_use = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    #10 reset = 1'b1;
    d_mlu_use = 1'b0;

    run_op(MULT,  32'hFFFF_FFFE, 32'd3,        1'b0, MULT_N);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFFA);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MULT_N);
    chk("multu_hi_const", hi, 32'hFFFF_FFFE);
    chk("multu_lo_const", lo, 32'h0000_0001);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,        1'b1, DIV_N);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);
    run_op(DIVU,  32'd7,         32'd0,        1'b0, DIV_N);
    chk("div0_hi_keep", hi, 32'hFFFF_FFFF);
    chk("div0_lo_keep", lo, 32'hFFFF_FFFD);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, DIV_N);
    chk("ovf_lo_const", lo, 32'h8000_0000);
    chk("ovf_hi_const", hi, 32'h0000_0000);
    run_op(DIVU,  32'd100,       32'd7,        1'b0, DIV_N);

    for (int k = 0; k < 4; k++) begin
      logic [3:0] ro;
      ro = 4'(k + 1);
      run_op(ro, $urandom, $urandom, 1'($urandom_range(0, 1)),
             (ro == MULT || ro == MULTU) ? MULT_N : DIV_N);
    end

    move_to(MTHI, 32'h1234_5678);
    @(posedge clk); #1;
    start = 1'b1; op = MFHI; d_mlu_use = 1'b1;
    #1 chk("mfhi_rdata", rdata, 32'h1234_5678);
    chk("mfhi_nostall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NONE; d_mlu_use = 1'b0;
    #1 chk("none_rdata", rdata, 32'd0);
    move_to(MTLO, 32'hCAFE_F00D);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    op = MFLO;
    #1 chk("mflo_rdata", rdata, 32'hCAFE_F00D);

`ifdef MDU_FLUSH_EN
    @(posedge clk); #1;
    start = 1'b1; op = MULT; rs_val = 32'd9; rt_val = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);
    @(posedge clk); #1;
    start = 1'b1; op = MTHI; rs_val = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_mthi", hi, m_hi);
`endif

    @(posedge clk); #1;
    start = 1'b1; op = MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    m_hi = '0;
    m_lo = '0;
    #5 reset = 1'b1;
    run_op(MULTU, 32'd3, 32'd4, 1'b1, MULT_N);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
